// File: rtl/hue_pwm_pkg.sv
// hue_pwm_pkg: shared mode enum, duty struct, sector indices and step-interval helper
package hue_pwm_pkg;
  localparam int DUTY_W = 10;
  typedef enum logic [1:0] {
    M_RUN  = 2'd0,
    M_HOLD = 2'd1,
    M_STEP = 2'd2,
    M_OFF  = 2'd3
  } mode_e;
  typedef struct packed {
    logic [DUTY_W-1:0] r;
    logic [DUTY_W-1:0] g;
    logic [DUTY_W-1:0] b;
  } rgb_duty_t;
  localparam logic [2:0] SEC_RY = 3'd0;
  localparam logic [2:0] SEC_YG = 3'd1;
  localparam logic [2:0] SEC_GC = 3'd2;
  localparam logic [2:0] SEC_CB = 3'd3;
  localparam logic [2:0] SEC_BM = 3'd4;
  localparam logic [2:0] SEC_MR = 3'd5;
  function automatic int step_cycles(input int clk_hz, input int cycle_ms, input int hue_max);
    longint c;
    c = longint'(clk_hz) * longint'(cycle_ms) / 1000 / longint'(hue_max);
    return c < 1 ? 1 : int'(c);
  endfunction
endpackage

// File: rtl/hue_pwm_engine_sector_map.sv
// hue_sector_map: registered hue-to-RGB raw duty mapping for one channel
//   clk, rst : clock, synchronous active-high reset
//   hue_k    : channel hue, 0..6*SEG_LEN-1
//   rgb_q    : registered raw R/G/B duties
module hue_sector_map
  import hue_pwm_pkg::*;
#(
  parameter int SEG_LEN  = 64,
  parameter int PWM_BITS = 10,
  parameter int HUE_W    = $clog2(6 * SEG_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [HUE_W-1:0] hue_k,
  output rgb_duty_t        rgb_q
);
  localparam int SEG_W = $clog2(SEG_LEN);
  localparam int SH = PWM_BITS - SEG_W;
  logic [2:0] s;
  logic [SEG_W-1:0] p;
  logic [PWM_BITS-1:0] up, dn, full;
  rgb_duty_t rgb_d;
  always_comb begin
    s = hue_k[SEG_W +: 3];
    p = hue_k[SEG_W-1:0];
    up = PWM_BITS'(p) << SH;
    // ~p equals SEG_LEN-1-p for a power-of-two sector length
    dn = PWM_BITS'(~p) << SH;
    full = '1;
    rgb_d.r = DUTY_W'((s == SEC_RY || s == SEC_MR) ? full : s == SEC_YG ? dn : s == SEC_BM ? up : '0);
    rgb_d.g = DUTY_W'((s == SEC_YG || s == SEC_GC) ? full : s == SEC_RY ? up : s == SEC_CB ? dn : '0);
    rgb_d.b = DUTY_W'((s == SEC_CB || s == SEC_BM) ? full : s == SEC_GC ? up : s == SEC_MR ? dn : '0);
  end
  always_ff @(posedge clk) begin
    if (rst) rgb_q <= '0;
    else rgb_q <= rgb_d;
  end
endmodule

// File: rtl/hue_pwm_engine.sv
// hue_pwm_engine: multi-channel hue-wheel RGB PWM driver with run/hold/step/off control
//   clk, rst            : clock, synchronous active-high reset
//   mode                : 0 RUN, 1 HOLD, 2 STEP, 3 OFF
//   step_req            : single-step pulse, honoured in STEP only
//   brightness          : global scale, 255 = full
//   pwm_r/pwm_g/pwm_b   : per-channel pin drives
//   hue                 : channel-0 hue
//   rev_done            : one-cycle pulse after the hue wraps to 0
module hue_pwm_engine
  import hue_pwm_pkg::*;
#(
  parameter int CLK_HZ   = 12_000_000,
  parameter int CYCLE_MS = 1000,
  parameter int SEG_LEN  = 64,
  parameter int PWM_BITS = 10,
  parameter int N_CH     = 2,
  parameter int HUE_W    = $clog2(6 * SEG_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             step_req,
  input  logic [7:0]       brightness,
  output logic [N_CH-1:0]  pwm_r,
  output logic [N_CH-1:0]  pwm_g,
  output logic [N_CH-1:0]  pwm_b,
  output logic [HUE_W-1:0] hue,
  output logic             rev_done
);
  localparam int HUE_MAX = 6 * SEG_LEN;
  localparam int STEP_CYC = step_cycles(CLK_HZ, CYCLE_MS, HUE_MAX);
  localparam int PRE_W = STEP_CYC > 1 ? $clog2(STEP_CYC) : 1;
  localparam int CH_OFS = HUE_MAX / N_CH;
  localparam logic [PWM_BITS-1:0] FULL = '1;
  localparam logic [HUE_W-1:0] HUE_LAST = HUE_W'(HUE_MAX - 1);
  mode_e state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [HUE_W-1:0] hue_q, hue_d;
  logic rev_q, rev_d;
  logic [7:0] bri_q;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0][PWM_BITS-1:0] dr_q, dg_q, db_q, dr_d, dg_d, db_d;
  logic [N_CH-1:0][PWM_BITS-1:0] ar_q, ag_q, ab_q, ar_d, ag_d, ab_d;
  logic [N_CH-1:0][HUE_W-1:0] hue_k;
  logic [HUE_W:0] sum;
  rgb_duty_t map_q [N_CH];
  logic tick, adv, ld;
  function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] raw, input logic [7:0] b);
    logic [PWM_BITS+8:0] prod;
    prod = (PWM_BITS + 9)'(raw) * (PWM_BITS + 9)'({1'b0, b} + 9'd1);
    return PWM_BITS'(prod >> 8);
  endfunction
  for (genvar k = 0; k < N_CH; k++) begin : g_map
    hue_sector_map #(.SEG_LEN(SEG_LEN), .PWM_BITS(PWM_BITS), .HUE_W(HUE_W)) u_map (
      .clk   (clk),
      .rst   (rst),
      .hue_k (hue_k[k]),
      .rgb_q (map_q[k])
    );
  end
  always_comb begin
    state_d = mode_e'(mode);
    tick = pre_q == PRE_W'(STEP_CYC - 1);
    adv = (state_q == M_RUN && tick) || (state_q == M_STEP && step_req);
    // prescaler only runs in RUN, so every entry into RUN starts from 0
    pre_d = (state_q == M_RUN && !tick) ? pre_q + PRE_W'(1) : '0;
    hue_d = !adv ? hue_q : hue_q == HUE_LAST ? '0 : hue_q + HUE_W'(1);
    rev_d = adv && hue_q == HUE_LAST;
    cnt_d = cnt_q + PWM_BITS'(1);
    // new duty is adopted only at the counter wrap so a period is never cut short
    ld = cnt_q == FULL;
    hue = hue_q;
    rev_done = rev_q;
    sum = '0;
    hue_k = '0;
    dr_d = '0;
    dg_d = '0;
    db_d = '0;
    ar_d = '0;
    ag_d = '0;
    ab_d = '0;
    pwm_r = '0;
    pwm_g = '0;
    pwm_b = '0;
    for (int i = 0; i < N_CH; i++) begin
      sum = {1'b0, hue_q} + (HUE_W + 1)'(i * CH_OFS);
      hue_k[i] = sum >= (HUE_W + 1)'(HUE_MAX) ? HUE_W'(sum - (HUE_W + 1)'(HUE_MAX)) : HUE_W'(sum);
      dr_d[i] = scale(PWM_BITS'(map_q[i].r), bri_q);
      dg_d[i] = scale(PWM_BITS'(map_q[i].g), bri_q);
      db_d[i] = scale(PWM_BITS'(map_q[i].b), bri_q);
      ar_d[i] = ld ? dr_q[i] : ar_q[i];
      ag_d[i] = ld ? dg_q[i] : ag_q[i];
      ab_d[i] = ld ? db_q[i] : ab_q[i];
      pwm_r[i] = state_q != M_OFF && cnt_q < ar_q[i];
      pwm_g[i] = state_q != M_OFF && cnt_q < ag_q[i];
      pwm_b[i] = state_q != M_OFF && cnt_q < ab_q[i];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= M_HOLD;
      pre_q <= '0;
      hue_q <= '0;
      rev_q <= 1'b0;
      bri_q <= '0;
      cnt_q <= '0;
      dr_q <= '0;
      dg_q <= '0;
      db_q <= '0;
      ar_q <= '0;
      ag_q <= '0;
      ab_q <= '0;
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      hue_q <= hue_d;
      rev_q <= rev_d;
      bri_q <= brightness;
      cnt_q <= cnt_d;
      dr_q <= dr_d;
      dg_q <= dg_d;
      db_q <= db_d;
      ar_q <= ar_d;
      ag_q <= ag_d;
      ab_q <= ab_d;
    end
  end
endmodule

// File: tb/tb_hue_pwm_engine.sv
// tb_hue_pwm_engine: randomized scoreboard bench for hue_pwm_engine
module tb_hue_pwm_engine;
  import hue_pwm_pkg::*;
  localparam int CLK_HZ = 3840, CYCLE_MS = 1000, SEG_LEN = 64, PWM_BITS = 10, N_CH = 2;
  localparam int HUE_MAX = 6 * SEG_LEN;
  localparam int STEP_CYC = CLK_HZ * CYCLE_MS / 1000 / HUE_MAX;
  localparam int PER = 1 << PWM_BITS;
  localparam int FULLV = PER - 1;
  localparam int SHV = PER / SEG_LEN;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] mode = 2'd1;
  logic step_req = 1'b0;
  logic [7:0] brightness = 8'd255;
  logic [N_CH-1:0] pwm_r, pwm_g, pwm_b;
  logic [8:0] hue;
  logic rev_done;
  int n_chk = 0, n_fail = 0;
  typedef struct {int n; int h; bit rev;} ev_t;
  ev_t evq[$];
  int pq[$];
  int m_n = 0, m_h = 0, m_e = 0;
  logic [1:0] m_s = 2'd1;
  int m_duty[6], m_acc[6], hh[8], bb[8];
  string cn[3] = '{"r", "g", "b"};

  hue_pwm_engine #(.CLK_HZ(CLK_HZ), .CYCLE_MS(CYCLE_MS), .SEG_LEN(SEG_LEN), .PWM_BITS(PWM_BITS), .N_CH(N_CH)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .step_req   (step_req),
    .brightness (brightness),
    .pwm_r      (pwm_r),
    .pwm_g      (pwm_g),
    .pwm_b      (pwm_b),
    .hue        (hue),
    .rev_done   (rev_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int raw_of(input int hk, input int col);
    int s, p, up, dn;
    s = hk / SEG_LEN;
    p = hk % SEG_LEN;
    up = p * SHV;
    dn = (SEG_LEN - 1 - p) * SHV;
    case (s)
      0: return col == 0 ? FULLV : col == 1 ? up : 0;
      1: return col == 0 ? dn : col == 1 ? FULLV : 0;
      2: return col == 1 ? FULLV : col == 2 ? up : 0;
      3: return col == 1 ? dn : col == 2 ? FULLV : 0;
      4: return col == 0 ? up : col == 2 ? FULLV : 0;
      default: return col == 0 ? FULLV : col == 2 ? dn : 0;
    endcase
  endfunction

  function automatic int exp_duty(input int h, input int i, input int b);
    int hk;
    hk = (h + (i / 3) * (HUE_MAX / N_CH)) % HUE_MAX;
    return raw_of(hk, i % 3) * (b + 1) / 256;
  endfunction

  function automatic logic pin_of(input int i);
    return i % 3 == 0 ? pwm_r[i / 3] : i % 3 == 1 ? pwm_g[i / 3] : pwm_b[i / 3];
  endfunction

  // reference model: hue advances every STEP_CYC cycles counted from RUN entry, or on a
  // step pulse in STEP; a period's duty comes from hue/brightness three cycles before it starts
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_n = 0;
      m_h = 0;
      m_s = M_HOLD;
      evq.delete();
      pq.delete();
    end else begin
      m_n++;
      if ((m_s == M_RUN && m_n > m_e && (m_n - m_e) % STEP_CYC == 0) || (m_s == M_STEP && step_req)) begin
        m_h = (m_h + 1) % HUE_MAX;
        evq.push_back('{m_n, m_h, m_h == 0});
      end
      if (mode == M_RUN && m_s != M_RUN) m_e = m_n;
      m_s = mode;
    end
    hh[m_n % 8] = m_h;
    bb[m_n % 8] = brightness;
    if (m_n % PER == 0)
      for (int i = 0; i < 6; i++) begin
        m_duty[i] = m_n == 0 ? 0 : exp_duty(hh[(m_n - 3) % 8], i, bb[(m_n - 2) % 8]);
        m_acc[i] = 0;
      end
    for (int i = 0; i < 6; i++) m_acc[i] += (m_s != M_OFF && (m_n % PER) < m_duty[i]) ? 1 : 0;
    if (m_n % PER == PER - 1)
      for (int i = 0; i < 6; i++) pq.push_back(m_acc[i]);
  end

  // monitor: pops an expected event on every hue change or rev_done, and one
  // expected high-count per pin at the end of each PWM period
  initial begin
    int mn, last_h, c;
    int acc[6];
    logic r;
    ev_t e;
    mn = 0;
    last_h = 0;
    forever begin
      @(posedge clk);
      r = rst;
      #1;
      if (r) begin
        mn = 0;
        last_h = 0;
        chk("reset_hue", 32'(hue), 0);
        chk("reset_rev_done", 32'(rev_done), 0);
        chk("reset_pwm", 32'({pwm_r, pwm_g, pwm_b}), 0);
      end else begin
        mn++;
        while (evq.size() > 0 && evq[0].n < mn) begin
          e = evq.pop_front();
          n_chk++;
          n_fail++;
          $display("FAIL hue_missed: hue stayed %0d, expected %0d at cycle %0d", hue, e.h, e.n);
        end
        if (int'(hue) != last_h || rev_done) begin
          if (evq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL hue_unexpected: got hue %0d rev_done %0b at cycle %0d, expected no change", hue, rev_done, mn);
          end else begin
            e = evq.pop_front();
            chk("hue_cycle", 32'(mn), 32'(e.n));
            chk("hue_value", 32'(hue), 32'(e.h));
            chk("rev_done", 32'(rev_done), 32'(e.rev));
          end
          last_h = int'(hue);
        end
      end
      c = mn % PER;
      if (c == 0) foreach (acc[i]) acc[i] = 0;
      for (int i = 0; i < 6; i++) acc[i] += pin_of(i) === 1'b1 ? 1 : 0;
      if (c == PER - 1)
        for (int i = 0; i < 6; i++) begin
          if (pq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL pwm_%s_ch%0d: got %0d high cycles, expected none queued", cn[i % 3], i / 3, acc[i]);
          end else chk($sformatf("pwm_%s_ch%0d_highs", cn[i % 3], i / 3), 32'(acc[i]), 32'(pq.pop_front()));
        end
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_cnt(input int t);
    for (int k = 0; k < PER + 2 && m_n % PER != t; k++) cycles(1);
  endtask

  task automatic wait_hue(input int v);
    for (int k = 0; k < 2 * HUE_MAX * STEP_CYC && m_h != v; k++) cycles(1);
  endtask

  initial begin
    int len;
    cycles(3);
    rst = 1'b0;
    mode = M_HOLD;
    cycles(2100);
    mode = M_RUN;
    cycles(3900);
    wait_hue(100);
    mode = M_HOLD;
    cycles(5000);
    mode = M_RUN;
    cycles(300);
    mode = M_HOLD;
    step_req = 1'b1;
    cycles(1);
    step_req = 1'b0;
    cycles(2);
    mode = M_STEP;
    step_req = 1'b1;
    cycles(1);
    step_req = 1'b0;
    cycles(4);
    repeat (5) begin
      step_req = 1'b1;
      cycles(1);
      step_req = 1'b0;
      cycles(2);
    end
    cycles(40);
    mode = M_HOLD;
    wait_cnt(500);
    brightness = 8'd63;
    cycles(2200);
    repeat (20) begin
      mode = 2'($urandom_range(0, 3));
      brightness = 8'($urandom);
      len = $urandom_range(50, 600);
      for (int i = 0; i < len; i++) begin
        step_req = $urandom_range(0, 3) == 0;
        cycles(1);
      end
    end
    step_req = 1'b0;
    mode = M_RUN;
    brightness = 8'd255;
    wait_cnt(300);
    mode = M_OFF;
    cycles(PER);
    wait_cnt(600);
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    mode = M_HOLD;
    cycles(2100);
    chk("events_drained", 32'(evq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
